// File: rtl/jelly_data_width_convert_pkg.sv
// jelly_data_width_convert_pkg: shared constants, unit type and endian-aware unit placement helpers
package jelly_data_width_convert_pkg;

    localparam int DEFAULT_UNIT_WIDTH = 8;

    typedef logic [DEFAULT_UNIT_WIDTH-1:0] unit_t;

    function automatic int calc_buf_num(input int s_num, input int m_num);
        return s_num + m_num;
    endfunction

    function automatic int calc_count_width(input int buf_num);
        return $clog2(buf_num + 1);
    endfunction

    // lane of the idx-th unit (oldest first) within a beat of num units; used to pack and unpack beats
    function automatic int unit_lane(input int idx, input int num, input logic endian);
        return endian ? num - 1 - idx : idx;
    endfunction

endpackage

// File: rtl/jelly_data_unit_shift_buffer.sv
// jelly_data_unit_shift_buffer: unit buffer that drops the oldest M_NUM units and writes S_NUM units at an index
module jelly_data_unit_shift_buffer #(
    parameter int                    UNIT_WIDTH  = 8,
    parameter int                    BUF_NUM     = 8,
    parameter int                    S_NUM       = 3,
    parameter int                    M_NUM       = 5,
    parameter int                    COUNT_WIDTH = 4,
    parameter logic [UNIT_WIDTH-1:0] FILL_DATA   = '0
)(
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                cke,
    input  logic                                shift,
    input  logic                                write,
    input  logic [COUNT_WIDTH-1:0]              write_index,
    input  logic [S_NUM-1:0][UNIT_WIDTH-1:0]    write_data,
    output logic [BUF_NUM-1:0][UNIT_WIDTH-1:0]  units
);

    logic [BUF_NUM+M_NUM-1:0][UNIT_WIDTH-1:0] ext;
    logic [BUF_NUM-1:0][UNIT_WIDTH-1:0]       units_next;

    assign ext = {{M_NUM{FILL_DATA}}, units};

    // shift out emitted units first, then place the new beat at the post-shift fill level
    always_comb begin
        for (int i = 0; i < BUF_NUM; i++) begin
            units_next[i] = shift ? ext[i + M_NUM] : units[i];
            for (int j = 0; j < S_NUM; j++)
                if (write && int'(write_index) + j == i) units_next[i] = write_data[j];
        end
    end

    // buffer register, frozen while cke is low
    always_ff @(posedge clk)
        if (reset) units <= '0;
        else if (cke) units <= units_next;

endmodule

// File: rtl/jelly_data_width_convert.sv
// jelly_data_width_convert: S_NUM-unit to M_NUM-unit stream width converter (packet last/padding with JELLY_DATA_WIDTH_CONVERT_LAST_EN)
module jelly_data_width_convert
    import jelly_data_width_convert_pkg::*;
#(
    parameter int                    UNIT_WIDTH   = DEFAULT_UNIT_WIDTH,
    parameter int                    S_NUM        = 3,
    parameter int                    M_NUM        = 5,
    parameter int                    BUF_NUM      = calc_buf_num(S_NUM, M_NUM),
    parameter logic [UNIT_WIDTH-1:0] PADDING_DATA = '0
)(
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          cke,
    input  logic                          endian,
    input  logic [S_NUM*UNIT_WIDTH-1:0]   s_data,
`ifdef JELLY_DATA_WIDTH_CONVERT_LAST_EN
    input  logic                          s_last,
    output logic                          m_last,
`endif
    input  logic                          s_valid,
    output logic                          s_ready,
    output logic [M_NUM*UNIT_WIDTH-1:0]   m_data,
    output logic                          m_valid,
    input  logic                          m_ready
);

    localparam int CW = calc_count_width(BUF_NUM);

    logic [CW-1:0]                       count, emit_num, write_index;
    logic [BUF_NUM-1:0][UNIT_WIDTH-1:0]  units;
    logic [S_NUM-1:0][UNIT_WIDTH-1:0]    s_units;
    logic                                emit, accept, pending;

    assign s_ready     = !reset && !pending && (int'(count) + S_NUM <= BUF_NUM);
    assign m_valid     = pending ? (count != '0) : (int'(count) >= M_NUM);
    assign emit        = cke && m_valid && m_ready;
    assign accept      = cke && s_valid && s_ready;
    assign emit_num    = !emit ? '0 : (pending && int'(count) < M_NUM) ? count : CW'(M_NUM);
    assign write_index = count - emit_num;

    // unpack the input beat into oldest-first unit order
    always_comb begin
        for (int j = 0; j < S_NUM; j++)
            s_units[j] = s_data[unit_lane(j, S_NUM, endian)*UNIT_WIDTH +: UNIT_WIDTH];
    end

    // present the oldest M_NUM units; slots past the fill level of a flushing packet carry the padding unit
    always_comb begin
        m_data = '0;
        for (int i = 0; i < M_NUM; i++)
            m_data[unit_lane(i, M_NUM, endian)*UNIT_WIDTH +: UNIT_WIDTH] =
                (pending && i >= int'(count)) ? PADDING_DATA : units[i];
    end

    // fill level: drop emitted units, add accepted ones
    always_ff @(posedge clk)
        if (reset) count <= '0;
        else if (cke) count <= write_index + (accept ? CW'(S_NUM) : '0);

`ifdef JELLY_DATA_WIDTH_CONVERT_LAST_EN
    // a last beat blocks further input until its final unit has left
    always_ff @(posedge clk)
        if (reset) pending <= 1'b0;
        else if (cke) pending <= (pending && !(emit && m_last)) || (accept && s_last);
    assign m_last = pending && (count <= CW'(M_NUM));
`else
    assign pending = 1'b0;
`endif

    jelly_data_unit_shift_buffer #(
        .UNIT_WIDTH  (UNIT_WIDTH),
        .BUF_NUM     (BUF_NUM),
        .S_NUM       (S_NUM),
        .M_NUM       (M_NUM),
        .COUNT_WIDTH (CW),
        .FILL_DATA   (PADDING_DATA)
    ) u_buf (
        .clk         (clk),
        .reset       (reset),
        .cke         (cke),
        .shift       (emit),
        .write       (accept),
        .write_index (write_index),
        .write_data  (s_units),
        .units       (units)
    );

endmodule

// File: tb/tb_jelly_data_width_convert.sv
// tb_jelly_data_width_convert: directed and scoreboarded checks of the 3:5 converter plus a 5:1 throughput instance
module tb_jelly_data_width_convert;

    logic        clk = 1'b0, reset = 1'b1, cke = 1'b1, endian = 1'b0;
    logic [23:0] s_data = '0;
    logic        s_valid = 1'b0, s_ready, m_valid, m_ready = 1'b0;
    logic [39:0] m_data;
    logic [39:0] s_data2 = '0;
    logic        s_valid2 = 1'b0, s_ready2, m_valid2, m_ready2 = 1'b0;
    logic [7:0]  m_data2;
`ifdef JELLY_DATA_WIDTH_CONVERT_LAST_EN
    logic        s_last = 1'b0, m_last, s_last2 = 1'b0, m_last2;
`endif
    int          n_checks = 0, n_fail = 0;

    always #5 clk = ~clk;

    jelly_data_width_convert #(.UNIT_WIDTH(8), .S_NUM(3), .M_NUM(5)) dut (
        .clk(clk), .reset(reset), .cke(cke), .endian(endian), .s_data(s_data),
`ifdef JELLY_DATA_WIDTH_CONVERT_LAST_EN
        .s_last(s_last), .m_last(m_last),
`endif
        .s_valid(s_valid), .s_ready(s_ready), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready)
    );

    jelly_data_width_convert #(.UNIT_WIDTH(8), .S_NUM(5), .M_NUM(1)) dut2 (
        .clk(clk), .reset(reset), .cke(cke), .endian(1'b0), .s_data(s_data2),
`ifdef JELLY_DATA_WIDTH_CONVERT_LAST_EN
        .s_last(s_last2), .m_last(m_last2),
`endif
        .s_valid(s_valid2), .s_ready(s_ready2), .m_data(m_data2), .m_valid(m_valid2), .m_ready(m_ready2)
    );

    typedef struct {
        logic        sv;
        logic        mr;
        logic [23:0] sd;
        logic        er;
        logic        ev;
        logic [39:0] ed;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [23:0] pack_s(input int base, input logic e);
        logic [23:0] d;
        d = '0;
        for (int j = 0; j < 3; j++) d[(e ? 2 - j : j)*8 +: 8] = 8'(base + j);
        return d;
    endfunction

    function automatic logic [39:0] pack_m(input int base, input logic e);
        logic [39:0] d;
        d = '0;
        for (int i = 0; i < 5; i++) d[(e ? 4 - i : i)*8 +: 8] = 8'(base + i);
        return d;
    endfunction

    initial begin
        int next_in, next_out, n2, o2;
        vecs[0] = '{1'b1, 1'b1, 24'h020100, 1'b1, 1'b0, 40'h0000000000};
        vecs[1] = '{1'b1, 1'b1, 24'h050403, 1'b1, 1'b0, 40'h0000020100};
        vecs[2] = '{1'b1, 1'b1, 24'h080706, 1'b0, 1'b1, 40'h0403020100};
        vecs[3] = '{1'b1, 1'b1, 24'h080706, 1'b1, 1'b0, 40'h0000000005};
        vecs[4] = '{1'b1, 1'b1, 24'h0B0A09, 1'b1, 1'b0, 40'h0008070605};
        vecs[5] = '{1'b0, 1'b0, 24'h000000, 1'b0, 1'b1, 40'h0908070605};
        vecs[6] = '{1'b1, 1'b1, 24'h0E0D0C, 1'b0, 1'b1, 40'h0908070605};
        vecs[7] = '{1'b1, 1'b1, 24'h0E0D0C, 1'b1, 1'b0, 40'h0000000B0A};
        vecs[8] = '{1'b1, 1'b1, 24'h11100F, 1'b1, 1'b1, 40'h0E0D0C0B0A};
        vecs[9] = '{1'b0, 1'b1, 24'h000000, 1'b1, 1'b0, 40'h000011100F};

        s_valid = 1'b1;
        s_data  = 24'hAABBCC;
        for (int c = 0; c < 10; c++) begin
            tick;
            #2;
            check("reset_outputs", {s_ready, m_valid, m_data}, 42'h0);
        end
        s_valid = 1'b0;
        reset   = 1'b0;

        for (int i = 0; i < 10; i++) begin
            s_valid = vecs[i].sv;
            m_ready = vecs[i].mr;
            s_data  = vecs[i].sd;
            #2;
            check($sformatf("vec%0d_s_ready", i), s_ready, vecs[i].er);
            check($sformatf("vec%0d_m_valid", i), m_valid, vecs[i].ev);
            check($sformatf("vec%0d_m_data", i), m_data, vecs[i].ed);
            tick;
        end

        cke     = 1'b0;
        s_valid = 1'b1;
        m_ready = 1'b1;
        s_data  = 24'h141312;
        for (int c = 0; c < 3; c++) begin
            #2;
            check("cke_hold", {s_ready, m_valid, m_data}, {2'b10, 40'h000011100F});
            tick;
        end
        s_valid = 1'b0;
        cke     = 1'b1;
        #2;
        check("cke_resume", {s_ready, m_valid, m_data}, {2'b10, 40'h000011100F});

        reset = 1'b1;
        tick;
        #2;
        check("midstream_reset", {s_ready, m_valid, m_data}, 42'h0);
        reset   = 1'b0;
        endian  = 1'b1;
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_data  = pack_s(0, 1'b1);
        tick;
        s_data = pack_s(3, 1'b1);
        tick;
        s_valid = 1'b0;
        #2;
        check("endian1_full", {s_ready, m_valid, m_data}, {2'b01, 40'h0001020304});
        m_ready = 1'b1;
        tick;
        #2;
        check("endian1_tail", {s_ready, m_valid, m_data}, {2'b10, 40'h0500000000});

        for (int e = 0; e < 2; e++) begin
            reset = 1'b1;
            tick;
            reset    = 1'b0;
            endian   = e[0];
            next_in  = 0;
            next_out = 0;
            for (int c = 0; c < 3000; c++) begin
                s_valid = 1'($urandom_range(0, 1));
                m_ready = 1'($urandom_range(0, 1));
                s_data  = pack_s(next_in, endian);
                #2;
                if (m_valid && m_ready) begin
                    check("random_stream", m_data, pack_m(next_out, endian));
                    next_out += 5;
                end
                if (s_valid && s_ready) next_in += 3;
                tick;
            end
            s_valid = 1'b0;
            m_ready = 1'b1;
            for (int c = 0; c < 4; c++) begin
                #2;
                if (m_valid) begin
                    check("random_drain", m_data, pack_m(next_out, endian));
                    next_out += 5;
                end
                tick;
            end
            check("random_no_loss", 1'(next_in - next_out < 5 && next_in > 100), 1'b1);
        end

        reset = 1'b1;
        tick;
        reset    = 1'b0;
        endian   = 1'b0;
        m_ready2 = 1'b1;
        n2 = 0;
        o2 = 0;
        for (int c = 0; c < 30; c++) begin
            s_valid2 = 1'b1;
            for (int j = 0; j < 5; j++) s_data2[j*8 +: 8] = 8'(n2 + j);
            #2;
            if (c >= 1) check("five_to_one_rate", {m_valid2, m_data2}, {1'b1, 8'(o2)});
            if (m_valid2) o2++;
            if (s_ready2) n2 += 5;
            tick;
        end
        s_valid2 = 1'b0;

`ifdef JELLY_DATA_WIDTH_CONVERT_LAST_EN
        reset = 1'b1;
        tick;
        reset   = 1'b0;
        m_ready = 1'b1;
        s_valid = 1'b1;
        s_data  = 24'h020100;
        tick;
        s_data = 24'h050403;
        tick;
        s_data = 24'h080706;
        s_last = 1'b1;
        #2;
        check("last_first_beat", {s_ready, m_valid, m_last, m_data}, {3'b010, 40'h0403020100});
        tick;
        #2;
        check("last_accept", {s_ready, m_valid, m_last}, 3'b100);
        tick;
        s_valid = 1'b0;
        s_last  = 1'b0;
        #2;
        check("last_padded_beat", {s_ready, m_valid, m_last, m_data}, {3'b011, 40'h0008070605});
        tick;
        #2;
        check("last_cleared", {s_ready, m_valid, m_last}, 3'b100);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
